ex_issue_ctrl: RTL and testbench
================================

Name: ex_issue_ctrl

Overview:
- Execute-stage sequencer between the ID/EX pipeline register and the EX/MEM register.
- Holds one decoded instruction, drives the ALU operands and op, and waits on the ALU `ready` for multi-cycle divide/remainder ops.
- Registers the ALU result for the memory stage under a valid/ready handshake.
- Generates the upstream stall (`in_ready` low) and handles flush, including flush in the middle of a divide.

Parameters:
- XLEN, 32, datapath width (matches riscv_pkg XLEN).
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  kill the held instruction and the output register.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block accepts the instruction this cycle.
- in_a  input  XLEN  operand A.
- in_b  input  XLEN  operand B.
- in_op  input  alu_op_e  ALU operation.
- in_rd  input  REG_ADDR_W  destination register.
- in_reg_write  input  1  writeback enable.
- in_pc  input  XLEN  instruction PC.
- alu_a  output  XLEN  to ALU a.
- alu_b  output  XLEN  to ALU b.
- alu_op  output  alu_op_e  to ALU op.
- alu_result  input  XLEN  from ALU result.
- alu_zero  input  1  from ALU zero.
- alu_ready  input  1  from ALU ready (1 for single-cycle ops; divider done for div/rem).
- out_valid  output  1  result valid to the MEM stage.
- out_ready  input  1  MEM stage accepts.
- out_result  output  XLEN  registered ALU result.
- out_zero  output  1  registered zero flag.
- out_rd  output  REG_ADDR_W  registered destination register.
- out_reg_write  output  1  registered writeback enable.
- out_pc  output  XLEN  registered PC.

Behaviour:

Storage:
- Hold register X: x_valid, a, b, op, rd, reg_write, pc.
- Output register O: out_* fields.
- FSM states: IDLE, EXEC, DIV_WAIT, DRAIN.

Reset (asynchronous):
- state=IDLE, x_valid=0.
- out_valid=0; out_result, out_zero, out_rd, out_reg_write, out_pc all 0.
- in_ready=1.
- alu_a=0, alu_b=0, alu_op=ALU_ADD.

ALU drive:
- When x_valid, alu_a/alu_b/alu_op are driven combinationally from X.
- Otherwise alu_a=0, alu_b=0, alu_op=ALU_ADD, so the divider never starts on idle cycles.

o_free: `!out_valid || out_ready`.

IDLE:
- in_ready=1.
- On `in_valid`, load X and go to EXEC (div/rem ops also go to EXEC first).

EXEC (X valid, first ALU cycle):
- If op is non-div and o_free: capture alu_result/alu_zero and X fields into O, set out_valid=1.
  - in_ready=1 this cycle: a new instruction is loaded into X (stay in EXEC), else go to IDLE.
  - Single-cycle latency: accepted at edge T, out_valid high from edge T+1.
- If op is non-div and !o_free: in_ready=0, hold X and the ALU inputs (stall).
- If op is DIV/DIVU/REM/REMU: go to DIV_WAIT, in_ready=0.

DIV_WAIT:
- in_ready=0; ALU inputs held stable from X every cycle until capture.
- When `alu_ready && o_free`: capture into O, clear x_valid, go to IDLE.
- If `alu_ready && !o_free`: keep holding the op (result stays valid while the op is held) until o_free.
- After a divide there is always exactly one bubble cycle with alu_op=ALU_ADD before the next instruction is presented, so the divider done/start can settle.

Output handshake:
- out_valid is cleared when `out_ready && !capture`.
- O fields are stable while `out_valid && !out_ready`.

Flush (highest priority, synchronous):
- out_valid cleared next edge.
- In IDLE or EXEC: x_valid cleared, state IDLE; an in_valid in the same cycle is NOT accepted (in_ready=0 when flush=1).
- In DIV_WAIT: go to DRAIN.
  - In DRAIN, X op/operands are kept on the ALU until `alu_ready`, and the result is discarded.
  - Then clear x_valid and go to IDLE.
  - in_ready=0 and out_valid=0 throughout DRAIN; a further flush in DRAIN has no extra effect.

Simultaneous events:
- Capture and out_ready in the same cycle: O reloads and out_valid stays 1.
- alu_ready is ignored in EXEC for non-div ops (ALU reports 1).

Reset mid-divide: all state returns to reset values immediately; the divider is reset by the same reset.

Test Plan:
1. ADD a=5,b=7 accepted at edge 1, out_ready=1 -> out_valid=1 at edge 2, out_result=12, out_zero=0; back-to-back SUB 3-3 next cycle -> out_result=0, out_zero=1 at edge 3.
2. out_ready=0 for 3 cycles with XOR in X -> in_ready=0, alu_* held, out_result/out_rd unchanged; out_ready=1 -> both results drain in order, none lost or duplicated.
3. DIV a=-20,b=3 with alu_ready after 33 cycles -> in_ready=0 throughout, out_result=0xFFFFFFFA captured on the ready cycle, one ALU_ADD bubble, then next instruction accepted.
4. REMU 10,3 then flush at cycle 5 of DIV_WAIT -> DRAIN until alu_ready, no out_valid, in_ready=0; then IDLE, next ADD completes normally with correct result.
5. flush asserted with in_valid=1 and out_valid=1 -> in_ready=0, out_valid=0 next edge, X empty.
6. Reset asserted asynchronously mid-divide -> out_valid=0, alu_op=ALU_ADD, in_ready=1 without a clock edge; normal operation after deassert.

Source files
------------

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: holds one decoded instruction, drives the
// ALU, waits out multi-cycle divides and registers the result for MEM.

package riscv_pkg;

    parameter int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_MUL  = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REM  = 4'd14,
        ALU_REMU = 4'd15
    } alu_op_e;

endpackage

module ex_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_a,
    input  logic [XLEN-1:0]       in_b,
    input  alu_op_e               in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [XLEN-1:0]       in_pc,

    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output alu_op_e               alu_op,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_ready,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic                  out_zero,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic [XLEN-1:0]       out_pc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        DIV_WAIT = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    state_e state;
    state_e state_nxt;

    // Hold register X
    logic                  x_valid;
    logic [XLEN-1:0]       x_a;
    logic [XLEN-1:0]       x_b;
    alu_op_e               x_op;
    logic [REG_ADDR_W-1:0] x_rd;
    logic                  x_reg_write;
    logic [XLEN-1:0]       x_pc;

    logic x_load;
    logic x_clear;
    logic capture;
    logic o_free;
    logic x_is_div;

    assign o_free   = !out_valid || out_ready;
    assign x_is_div = (x_op == ALU_DIV) || (x_op == ALU_DIVU) ||
                      (x_op == ALU_REM) || (x_op == ALU_REMU);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, upstream ready, X load/clear and O capture decisions
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        x_load    = 1'b0;
        x_clear   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        x_load    = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (flush) begin
                    x_clear   = 1'b1;
                    state_nxt = IDLE;
                end else if (x_is_div) begin
                    state_nxt = DIV_WAIT;
                end else if (o_free) begin
                    capture  = 1'b1;
                    in_ready = 1'b1;
                    if (in_valid) begin
                        x_load = 1'b1;
                    end else begin
                        x_clear   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DIV_WAIT: begin
                // Leaving through IDLE gives the divider its one ALU_ADD bubble.
                if (flush) begin
                    state_nxt = DRAIN;
                end else if (alu_ready && o_free) begin
                    capture   = 1'b1;
                    x_clear   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // Divider must finish on stable inputs; its result is dropped.
                if (alu_ready) begin
                    x_clear   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold register: load a new instruction or retire the current one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_valid     <= 1'b0;
            x_a         <= '0;
            x_b         <= '0;
            x_op        <= ALU_ADD;
            x_rd        <= '0;
            x_reg_write <= 1'b0;
            x_pc        <= '0;
        end else if (x_load) begin
            x_valid     <= 1'b1;
            x_a         <= in_a;
            x_b         <= in_b;
            x_op        <= in_op;
            x_rd        <= in_rd;
            x_reg_write <= in_reg_write;
            x_pc        <= in_pc;
        end else if (x_clear) begin
            x_valid     <= 1'b0;
        end
    end

    // ALU drive: idle cycles present ADD 0,0 so the divider never starts
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        if (x_valid) begin
            alu_a  = x_a;
            alu_b  = x_b;
            alu_op = x_op;
        end
    end

    // Output register toward MEM with valid/ready handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_pc        <= '0;
        end else if (flush) begin
            out_valid     <= 1'b0;
        end else if (capture) begin
            out_valid     <= 1'b1;
            out_result    <= alu_result;
            out_zero      <= alu_zero;
            out_rd        <= x_rd;
            out_reg_write <= x_reg_write;
            out_pc        <= x_pc;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Self-checking bench for ex_issue_ctrl: a behavioural ALU/divider drives the
// ALU side; directed vectors, hand sequences and a random scoreboard run.

module tb_ex_issue_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    alu_op_e     in_op;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [31:0] in_pc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_e     alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [31:0] out_pc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_issue_ctrl #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_rd(in_rd), .in_reg_write(in_reg_write), .in_pc(in_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_ready(alu_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_pc(out_pc)
    );

    function automatic bit is_div_op(alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // RISC-V RV32IM arithmetic, including divide-by-zero and overflow rules
    function automatic logic [31:0] alu_ref(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            ALU_LUI:  r = b;
            ALU_MUL:  r = 32'(a * b);
            ALU_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            ALU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:  r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            ALU_REMU: r = (b == 0) ? a : a % b;
            default:  r = 32'h0;
        endcase
        return r;
    endfunction

    // Behavioural ALU: divides report ready after div_lat cycles on a held op
    int unsigned div_cnt;
    int unsigned div_lat = 4;

    always @(posedge clk or posedge rst) begin
        if (rst)                     div_cnt <= 0;
        else if (!is_div_op(alu_op)) div_cnt <= 0;
        else if (div_cnt < 1000)     div_cnt <= div_cnt + 1;
    end

    always_comb begin
        alu_ready  = is_div_op(alu_op) ? (div_cnt >= div_lat) : 1'b1;
        alu_result = (is_div_op(alu_op) && !alu_ready) ? 32'hDEAD_BEEF
                                                       : alu_ref(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result == 32'h0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid     = v;
        in_op        = op;
        in_a         = a;
        in_b         = b;
        in_rd        = rd;
        in_reg_write = 1'b1;
        in_pc        = 32'h0000_1000 + {27'b0, rd} * 4;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Directed vector: inputs, expected combinational values before the edge,
    // expected registered outputs after the edge
    typedef struct {
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        pre_in_ready;
        alu_op_e     pre_op;
        logic [31:0] pre_a;
        logic        post_ov;
        logic [31:0] post_res;
        logic        post_zero;
        logic [4:0]  post_rd;
    } vec_t;

    function automatic vec_t mkv(logic f, logic v, logic ordy, alu_op_e op, logic [31:0] a,
                                 logic [31:0] b, logic [4:0] rd, logic pir, alu_op_e pop,
                                 logic [31:0] pa, logic ov, logic [31:0] res, logic z,
                                 logic [4:0] ord);
        vec_t t;
        t.flush = f; t.in_valid = v; t.out_ready = ordy; t.op = op; t.a = a; t.b = b;
        t.rd = rd; t.pre_in_ready = pir; t.pre_op = pop; t.pre_a = pa; t.post_ov = ov;
        t.post_res = res; t.post_zero = z; t.post_rd = ord;
        return t;
    endfunction

    // Random scoreboard
    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    alu_op_e     prev_op = ALU_ADD;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_res, prev_pc;
    logic [6:0]  prev_misc;
    int          n_xfer = 0;

    task automatic monitor_cycle();
        exp_t e;
        if (flush) chk("flush blocks in_ready", 32'(in_ready), 32'd0);
        if (is_div_op(alu_op)) chk("in_ready low during divide", 32'(in_ready), 32'd0);
        if (out_valid && prev_hold) begin
            chk("out_result stable", out_result, prev_res);
            chk("out_pc stable", out_pc, prev_pc);
            chk("out_zero/rd/rw stable", 32'({out_zero, out_rd, out_reg_write}), 32'(prev_misc));
        end
        prev_hold = out_valid && !out_ready && !flush;
        prev_res  = out_result;
        prev_pc   = out_pc;
        prev_misc = {out_zero, out_rd, out_reg_write};
        if (is_div_op(prev_op) && alu_op != prev_op)
            chk("bubble after divide", 32'((alu_op == ALU_ADD) && (alu_a == 0) && (alu_b == 0)), 32'd1);
        prev_op = alu_op;
        if (out_valid && out_ready && !flush) begin
            n_xfer++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious output: got result 0x%08h expected no transfer", out_result);
            end else begin
                e = q.pop_front();
                chk("rand out_result", out_result, e.res);
                chk("rand out_zero/rd/rw", 32'({out_zero, out_rd, out_reg_write}), 32'({e.zero, e.rd, e.rw}));
                chk("rand out_pc", out_pc, e.pc);
            end
        end
        if (flush) q.delete();
        if (in_valid && in_ready && !flush) begin
            e.res  = alu_ref(in_op, in_a, in_b);
            e.zero = (e.res == 32'h0);
            e.rd   = in_rd;
            e.rw   = in_reg_write;
            e.pc   = in_pc;
            q.push_back(e);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        int          edges;
        int          bad;
        int          bad_hold;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0);
        repeat (2) edge1();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("reset alu_a/alu_b", alu_a | alu_b, 32'd0);
        chk("reset out_result", out_result, 32'd0);
        chk("reset out_pc/rd", out_pc | 32'(out_rd), 32'd0);
        rst = 1'b0;
        edge1();

        // ---- directed vectors: back-to-back, stall, flush ----
        vecs.push_back(mkv(0,1,1,ALU_ADD,32'd5,32'd7,5'd1,    1,ALU_ADD,32'h0,  0,32'h0,0,5'd0));
        vecs.push_back(mkv(0,1,1,ALU_SUB,32'd3,32'd3,5'd2,    1,ALU_ADD,32'd5,  1,32'd12,0,5'd1));
        vecs.push_back(mkv(0,1,1,ALU_XOR,32'hF0,32'h0F,5'd3,  1,ALU_SUB,32'd3,  1,32'h0,1,5'd2));
        vecs.push_back(mkv(0,1,0,ALU_OR,32'd1,32'd2,5'd4,     0,ALU_XOR,32'hF0, 1,32'h0,1,5'd2));
        vecs.push_back(mkv(0,1,0,ALU_OR,32'd1,32'd2,5'd4,     0,ALU_XOR,32'hF0, 1,32'h0,1,5'd2));
        vecs.push_back(mkv(0,1,0,ALU_OR,32'd1,32'd2,5'd4,     0,ALU_XOR,32'hF0, 1,32'h0,1,5'd2));
        vecs.push_back(mkv(0,1,1,ALU_OR,32'd1,32'd2,5'd4,     1,ALU_XOR,32'hF0, 1,32'hFF,0,5'd3));
        vecs.push_back(mkv(0,0,1,ALU_ADD,32'd0,32'd0,5'd0,    1,ALU_OR,32'd1,   1,32'd3,0,5'd4));
        vecs.push_back(mkv(0,0,1,ALU_ADD,32'd0,32'd0,5'd0,    1,ALU_ADD,32'h0,  0,32'h0,0,5'd0));
        vecs.push_back(mkv(0,1,0,ALU_AND,32'hFF,32'h0F,5'd5,  1,ALU_ADD,32'h0,  0,32'h0,0,5'd0));
        vecs.push_back(mkv(0,1,0,ALU_ADD,32'd1,32'd1,5'd6,    1,ALU_AND,32'hFF, 1,32'h0F,0,5'd5));
        vecs.push_back(mkv(1,1,0,ALU_SUB,32'd9,32'd1,5'd7,    0,ALU_ADD,32'd1,  0,32'h0,0,5'd0));
        vecs.push_back(mkv(0,0,1,ALU_ADD,32'd0,32'd0,5'd0,    1,ALU_ADD,32'h0,  0,32'h0,0,5'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            flush     = vecs[i].flush;
            out_ready = vecs[i].out_ready;
            drive(vecs[i].in_valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            #3;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].pre_in_ready));
            chk($sformatf("vec%0d alu_op", i), 32'(alu_op), 32'(vecs[i].pre_op));
            chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].pre_a);
            edge1();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].post_ov));
            if (vecs[i].post_ov) begin
                chk($sformatf("vec%0d out_result", i), out_result, vecs[i].post_res);
                chk($sformatf("vec%0d out_zero", i), 32'(out_zero), 32'(vecs[i].post_zero));
                chk($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(vecs[i].post_rd));
            end
        end
        flush = 1'b0;

        // ---- DIV -20/3 with 33-cycle divider, then bubble and next ADD ----
        div_lat   = 33;
        out_ready = 1'b1;
        drive(1'b1, ALU_DIV, 32'hFFFF_FFEC, 32'd3, 5'd8);
        #3 chk("div accept in_ready", 32'(in_ready), 32'd1);
        edge1();
        drive(1'b1, ALU_ADD, 32'd2, 32'd2, 5'd9);
        edges = 0; bad = 0; bad_hold = 0;
        while (!out_valid && edges < 100) begin
            #3;
            if (in_ready) bad++;
            if (alu_op != ALU_DIV || alu_a != 32'hFFFF_FFEC || alu_b != 32'd3) bad_hold++;
            edge1();
            edges++;
        end
        chk("div in_ready low while waiting", 32'(bad), 32'd0);
        chk("div alu inputs held", 32'(bad_hold), 32'd0);
        chk("div capture edge", 32'(edges), 32'd34);
        chk("div out_result", out_result, 32'hFFFF_FFFA);
        chk("div out_rd", 32'(out_rd), 32'd8);
        #3;
        chk("div bubble alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("div bubble alu_a", alu_a, 32'd0);
        chk("div bubble in_ready", 32'(in_ready), 32'd1);
        edge1();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
        #3 chk("post-div add presented", alu_a, 32'd2);
        edge1();
        chk("post-div add out_valid", 32'(out_valid), 32'd1);
        chk("post-div add result", out_result, 32'd4);

        // ---- REMU 10,3 flushed in DIV_WAIT cycle 5, drain, then ADD ----
        div_lat = 12;
        drive(1'b1, ALU_REMU, 32'd10, 32'd3, 5'd10);
        edge1();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
        repeat (5) edge1();
        flush = 1'b1;
        edge1();
        flush = 1'b0;
        edges = 6; bad = 0;
        for (int k = 0; k < 100; k++) begin
            #3;
            if (in_ready) break;
            if (out_valid || alu_op != ALU_REMU) bad++;
            edge1();
            edges++;
        end
        chk("drain no out_valid, op held", 32'(bad), 32'd0);
        chk("drain exit edge", 32'(edges), 32'd13);
        chk("drain exit out_valid", 32'(out_valid), 32'd0);
        drive(1'b1, ALU_ADD, 32'd6, 32'd7, 5'd11);
        edge1();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
        edge1();
        chk("post-drain add out_valid", 32'(out_valid), 32'd1);
        chk("post-drain add result", out_result, 32'd13);
        chk("post-drain add rd", 32'(out_rd), 32'd11);

        // ---- asynchronous reset in the middle of a divide ----
        drive(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd12);
        edge1();
        drive(1'b1, ALU_DIV, 32'd100, 32'd7, 5'd13);
        edge1();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
        out_ready = 1'b0;
        repeat (5) edge1();
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        chk("pre-reset divide on alu", 32'(alu_op), 32'(ALU_DIV));
        #1 rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("async reset in_ready", 32'(in_ready), 32'd1);
        chk("async reset out_result", out_result, 32'd0);
        edge1();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'd8, 32'd9, 5'd14);
        edge1();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
        edge1();
        chk("post-reset add result", out_result, 32'd17);
        chk("post-reset add out_valid", 32'(out_valid), 32'd1);
        edge1();

        // ---- randomized traffic against the scoreboard ----
        div_lat = 3;
        q.delete();
        prev_op = alu_op;
        prev_hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 9) < 7, alu_op_e'($urandom_range(0, 15)),
                  rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)));
            in_reg_write = 1'($urandom_range(0, 1));
            in_pc        = $urandom;
            #3;
            monitor_cycle();
            edge1();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
        for (int c = 0; c < 50; c++) begin
            #3;
            monitor_cycle();
            edge1();
        end
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        chk("random transfers observed", 32'(n_xfer > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
